pifwb_i2c_bridge: RTL and testbench

Parametrised successor to the fixed-width PIF Wishbone/I2C sequencer. It drives the EFB hard-I2C slave through an external Wishbone master port, decodes incoming I2C bytes into address and data commands, and presents the XI register-interface strobes. New capabilities are selectable I2C channel base, parametrised address/subaddress/type-field widths, an independent write subaddress output, and a Wishbone ack timeout with error reporting.

---
 rtl/pifwb_i2c_bridge.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pifwb_i2c_bridge.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifwb_i2c_bridge.sv
// PIF Wishbone/I2C bridge: drives the EFB hard-I2C slave over Wishbone, decodes received
// I2C bytes into address/data commands and presents the XI register-interface strobes.
module pifwb_i2c_bridge #(
    parameter logic [7:0]           EFB_BASE    = 8'h40,
    parameter int unsigned          XA_BITS     = 3,
    parameter int unsigned          SUBA_BITS   = 3,
    parameter int unsigned          TYPE_BITS   = 2,
    parameter logic [TYPE_BITS-1:0] A_CODE      = 2'b01,
    parameter logic [TYPE_BITS-1:0] D_CODE      = 2'b10,
    parameter int unsigned          ACK_TIMEOUT = 255,
    parameter int unsigned          ERRCNT_BITS = 8
) (
    input  logic                   xclk,
    input  logic                   rst,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [7:0]             wb_adr_o,
    output logic [7:0]             wb_dat_o,
    input  logic [7:0]             wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic [7:0]             XO,
    output logic                   XI_PWr,
    output logic [XA_BITS-1:0]     XI_PRWA,
    output logic [7-TYPE_BITS:0]   XI_PD,
    output logic                   XI_PRdFinished,
    output logic [SUBA_BITS-1:0]   XI_PRdSubA,
    output logic [SUBA_BITS-1:0]   XI_PWrSubA,
    output logic                   err_timeout,
    output logic [ERRCNT_BITS-1:0] err_count
);

    localparam int unsigned PD_BITS  = 8 - TYPE_BITS;
    localparam int unsigned TMO_BITS = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(ACK_TIMEOUT - 1);

    localparam logic [7:0] ADR_CMDR = EFB_BASE + 8'd1;
    localparam logic [7:0] ADR_TXDR = EFB_BASE + 8'd4;
    localparam logic [7:0] ADR_SR   = EFB_BASE + 8'd5;
    localparam logic [7:0] ADR_RXDR = EFB_BASE + 8'd7;

    typedef enum logic [3:0] {
        StStart, StInitSr, StInitRx1, StInitRx2, StInitCe, StIdle,
        StDispatch, StIn0, StOut0, StOut1, StRd, StWr
    } state_e;

    state_e                 state_q, state_d, ret_q, ret_d;
    logic                   cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [7:0]             adr_q, adr_d, dat_q, dat_d, in_byte_q, in_byte_d;
    logic                   busy_q, busy_d, txrdy_q, txrdy_d, rxrdy_q, rxrdy_d;
    logic                   lastnak_q, lastnak_d;
    logic [TMO_BITS-1:0]    tmo_q, tmo_d;
    logic [XA_BITS-1:0]     prwa_q, prwa_d;
    logic [PD_BITS-1:0]     pd_q, pd_d;
    logic                   pwr_q, pwr_d, rdfin_q, rdfin_d, errto_q, errto_d;
    logic [SUBA_BITS-1:0]   rdsub_q, rdsub_d, wrsub_q, wrsub_d;
    logic [ERRCNT_BITS-1:0] errcnt_q, errcnt_d;

    // Bus-cycle request raised by the sequencing states, applied after the state decode.
    logic                   go_rd, go_wr;
    logic [7:0]             go_adr, go_dat;
    state_e                 go_ret;
    logic                   sr_busy;
    logic [TYPE_BITS-1:0]   in_type;

    assign sr_busy = wb_dat_i[6];
    assign in_type = in_byte_q[7 -: TYPE_BITS];

    // State and all registered outputs; reset drops the bus strobes immediately.
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            state_q   <= StStart;
            ret_q     <= StStart;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 8'h00;
            dat_q     <= 8'h00;
            in_byte_q <= 8'h00;
            busy_q    <= 1'b0;
            txrdy_q   <= 1'b0;
            rxrdy_q   <= 1'b0;
            lastnak_q <= 1'b0;
            tmo_q     <= '0;
            prwa_q    <= '0;
            pd_q      <= '0;
            pwr_q     <= 1'b0;
            rdfin_q   <= 1'b0;
            errto_q   <= 1'b0;
            rdsub_q   <= '0;
            wrsub_q   <= '0;
            errcnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            in_byte_q <= in_byte_d;
            busy_q    <= busy_d;
            txrdy_q   <= txrdy_d;
            rxrdy_q   <= rxrdy_d;
            lastnak_q <= lastnak_d;
            tmo_q     <= tmo_d;
            prwa_q    <= prwa_d;
            pd_q      <= pd_d;
            pwr_q     <= pwr_d;
            rdfin_q   <= rdfin_d;
            errto_q   <= errto_d;
            rdsub_q   <= rdsub_d;
            wrsub_q   <= wrsub_d;
            errcnt_q  <= errcnt_d;
        end
    end

    // Next-state: sequencing, Wishbone handshake with timeout, SR decode and XI updates.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        in_byte_d = in_byte_q;
        busy_d    = busy_q;
        txrdy_d   = txrdy_q;
        rxrdy_d   = rxrdy_q;
        lastnak_d = lastnak_q;
        tmo_d     = tmo_q;
        prwa_d    = prwa_q;
        pd_d      = pd_q;
        pwr_d     = 1'b0;
        rdfin_d   = 1'b0;
        errto_d   = 1'b0;
        rdsub_d   = rdsub_q;
        wrsub_d   = wrsub_q;
        errcnt_d  = errcnt_q;
        go_rd     = 1'b0;
        go_wr     = 1'b0;
        go_adr    = 8'h00;
        go_dat    = 8'h00;
        go_ret    = StIdle;

        // Subaddresses advance the clock after their strobe; an address byte overrides below.
        if (pwr_q)   wrsub_d = wrsub_q + 1'b1;
        if (rdfin_q) rdsub_d = rdsub_q + 1'b1;

        case (state_q)
            StStart: begin
                go_wr = 1'b1; go_adr = ADR_CMDR; go_dat = 8'h04; go_ret = StInitSr;
            end
            StInitSr: begin
                go_rd = 1'b1; go_adr = ADR_SR; go_ret = StInitSr;
            end
            StInitRx1: begin
                go_rd = 1'b1; go_adr = ADR_RXDR; go_ret = StInitRx2;
            end
            StInitRx2: begin
                go_rd = 1'b1; go_adr = ADR_RXDR; go_ret = StInitCe;
            end
            StInitCe: begin
                go_wr = 1'b1; go_adr = ADR_CMDR; go_dat = 8'h00; go_ret = StIdle;
            end
            StIdle: begin
                go_rd = 1'b1; go_adr = ADR_SR; go_ret = StIdle;
            end
            StDispatch: begin
                if (lastnak_q) begin
                    state_d = StStart;
                end else if (txrdy_q) begin
                    go_wr = 1'b1; go_adr = ADR_TXDR; go_dat = XO; go_ret = StOut0;
                end else if (rxrdy_q) begin
                    go_rd = 1'b1; go_adr = ADR_RXDR; go_ret = StIn0;
                end else if (!busy_q) begin
                    state_d = StStart;
                end else begin
                    go_rd = 1'b1; go_adr = ADR_SR; go_ret = StDispatch;
                end
            end
            StIn0: begin
                if (in_type == A_CODE) begin
                    prwa_d  = in_byte_q[XA_BITS-1:0];
                    rdsub_d = '0;
                    wrsub_d = '0;
                end else if (in_type == D_CODE) begin
                    pd_d  = in_byte_q[PD_BITS-1:0];
                    pwr_d = 1'b1;
                end
                state_d = StIdle;
            end
            StOut0: begin
                rdfin_d = 1'b1;
                state_d = StOut1;
            end
            StOut1: begin
                state_d = StIdle;
            end
            StRd, StWr: begin
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    tmo_d   = '0;
                    state_d = ret_q;
                    if (state_q == StRd && adr_q == ADR_SR) begin
                        // Flags come from this ack's data, not from an earlier read.
                        busy_d    = wb_dat_i[6];
                        txrdy_d   = wb_dat_i[6] & wb_dat_i[2] & wb_dat_i[4] & ~wb_dat_i[7];
                        rxrdy_d   = wb_dat_i[6] & wb_dat_i[2] & ~wb_dat_i[4];
                        lastnak_d = wb_dat_i[6] & wb_dat_i[5] & wb_dat_i[4] & wb_dat_i[1];
                        // Polling reads choose their follow-up from the fresh busy bit.
                        if (ret_q == StIdle) begin
                            state_d = sr_busy ? StDispatch : StIdle;
                        end else if (ret_q == StInitSr) begin
                            state_d = sr_busy ? StInitSr : StInitRx1;
                        end
                    end
                    if (state_q == StRd && adr_q == ADR_RXDR) begin
                        in_byte_d = wb_dat_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    tmo_d   = '0;
                    errto_d = 1'b1;
                    if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
                    state_d = StStart;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = StStart;
        endcase

        if (go_rd || go_wr) begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = go_wr;
            adr_d   = go_adr;
            dat_d   = go_dat;
            ret_d   = go_ret;
            tmo_d   = '0;
            state_d = go_wr ? StWr : StRd;
        end
    end

    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = stb_q;
    assign wb_we_o        = we_q;
    assign wb_adr_o       = adr_q;
    assign wb_dat_o       = dat_q;
    assign XI_PWr         = pwr_q;
    assign XI_PRWA        = prwa_q;
    assign XI_PD          = pd_q;
    assign XI_PRdFinished = rdfin_q;
    assign XI_PRdSubA     = rdsub_q;
    assign XI_PWrSubA     = wrsub_q;
    assign err_timeout    = errto_q;
    assign err_count      = errcnt_q;

endmodule

// File: tb/tb_pifwb_i2c_bridge.sv
// Bench for pifwb_i2c_bridge: EFB register model, vector table, random traffic vs a
// byte-level reference model, timeout and asynchronous-reset sequences.
module tb_pifwb_i2c_bridge;

    logic xclk = 1'b0;
    logic rst  = 1'b1;
    always #5 xclk = ~xclk;

    // Main DUT (default parameters)
    logic       wb_cyc, wb_stb, wb_we, wb_ack;
    logic [7:0] wb_adr, wb_dat_o, wb_dat_i, xo;
    logic       xi_pwr, xi_rdfin, err_to;
    logic [2:0] xi_prwa, rdsub, wrsub;
    logic [5:0] xi_pd;
    logic [7:0] err_cnt;

    pifwb_i2c_bridge u_dut (
        .xclk(xclk), .rst(rst),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .XO(xo),
        .XI_PWr(xi_pwr), .XI_PRWA(xi_prwa), .XI_PD(xi_pd), .XI_PRdFinished(xi_rdfin),
        .XI_PRdSubA(rdsub), .XI_PWrSubA(wrsub), .err_timeout(err_to), .err_count(err_cnt)
    );

    // Second DUT: I2C2 base and a short timeout for saturation
    logic       c2, s2, w2, ack2;
    logic [7:0] a2, d2, ec2;
    logic       p2, rf2, et2;
    logic [2:0] pa2, rs2, ws2;
    logic [5:0] pd2;
    logic       ack2_en = 1'b1;

    pifwb_i2c_bridge #(.EFB_BASE(8'h4A), .ACK_TIMEOUT(2)) u_dut2 (
        .xclk(xclk), .rst(rst),
        .wb_cyc_o(c2), .wb_stb_o(s2), .wb_we_o(w2), .wb_adr_o(a2),
        .wb_dat_o(d2), .wb_dat_i(8'h00), .wb_ack_i(ack2), .XO(8'h00),
        .XI_PWr(p2), .XI_PRWA(pa2), .XI_PD(pd2), .XI_PRdFinished(rf2),
        .XI_PRdSubA(rs2), .XI_PWrSubA(ws2), .err_timeout(et2), .err_count(ec2)
    );

    // EFB model
    logic       ack_en = 1'b1;
    logic [7:0] base_sr = 8'h00;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] sr_now, last_tx;
    int rx_posted = 0, rx_taken = 0, tx_posted = 0, tx_taken = 0;
    int n_start = 0, n_ce = 0, log_n;
    logic [16:0] log_e [32];

    always_comb begin
        sr_now = base_sr;
        if (rx_posted != rx_taken)      sr_now = 8'h44;
        else if (tx_posted != tx_taken) sr_now = 8'h54;
    end
    always_comb begin
        wb_dat_i = 8'h00;
        if (wb_adr == 8'h45)      wb_dat_i = sr_now;
        else if (wb_adr == 8'h47) wb_dat_i = rx_byte;
    end

    always @(posedge xclk or posedge rst) begin
        if (rst) begin
            wb_ack <= 1'b0;
            log_n  <= 0;
        end else begin
            wb_ack <= wb_cyc & wb_stb & ~wb_ack & ack_en;
            if (wb_ack && wb_cyc) begin
                if (log_n < 32) log_e[log_n] <= {wb_we, wb_adr, wb_we ? wb_dat_o : 8'h00};
                log_n <= log_n + 1;
                if (!wb_we && wb_adr == 8'h47 && rx_posted != rx_taken) rx_taken <= rx_taken + 1;
                if (wb_we && wb_adr == 8'h44 && tx_posted != tx_taken) begin
                    tx_taken <= tx_taken + 1;
                    last_tx  <= wb_dat_o;
                end
                if (wb_we && wb_adr == 8'h41 && wb_dat_o == 8'h04) n_start <= n_start + 1;
                if (wb_we && wb_adr == 8'h41 && wb_dat_o == 8'h00) n_ce <= n_ce + 1;
            end
        end
    end

    logic       got2 = 1'b0;
    logic [7:0] first_adr2, first_dat2;
    always @(posedge xclk or posedge rst) begin
        if (rst) begin
            ack2 <= 1'b0;
        end else begin
            ack2 <= c2 & s2 & ~ack2 & ack2_en;
            if (ack2 && w2 && !got2) begin
                got2       <= 1'b1;
                first_adr2 <= a2;
                first_dat2 <= d2;
            end
        end
    end

    // Output monitor, sampled on the falling edge
    int pwr_n, rdfin_n, to_n, to_hi, run, last_run, to2_n = 0;
    logic [5:0] last_pd;
    always @(negedge xclk) begin
        if (et2) to2_n <= to2_n + 1;
        if (rst) begin
            pwr_n <= 0; rdfin_n <= 0; to_n <= 0; to_hi <= 0; run <= 0; last_run <= 0;
        end else begin
            if (xi_pwr) pwr_n <= pwr_n + 1;
            if (xi_rdfin) rdfin_n <= rdfin_n + 1;
            if (err_to) begin
                to_hi <= to_hi + 1;
                if (to_hi == 0 || !err_to) to_n <= to_n + 1;
            end
            if (wb_cyc) run <= run + 1;
            else if (run != 0) begin
                last_run <= run;
                run      <= 0;
            end
        end
    end

    // Checking
    int n_tests = 0, n_fail = 0;
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge xclk);
    endtask

    // Reference model: byte-level meaning of the received and transmitted traffic
    int exp_prwa = 0, exp_pd = 0, exp_pwr = 0, exp_wrsub = 0, exp_rdsub = 0, exp_rdfin = 0;

    task automatic send_rx(input logic [7:0] b);
        int t;
        rx_byte = b;
        rx_posted++;
        for (int i = 0; i < 400 && rx_taken != rx_posted; i++) @(negedge xclk);
        check("rx byte consumed", rx_taken, rx_posted);
        tick(6);
        t = int'(b) / 64;
        if (t == 1) begin
            exp_prwa = int'(b) % 8; exp_wrsub = 0; exp_rdsub = 0;
        end else if (t == 2) begin
            exp_pd = int'(b) % 64; exp_pwr++; exp_wrsub = (exp_wrsub + 1) % 8;
        end
    endtask

    task automatic send_tx(input logic [7:0] b);
        xo = b;
        tx_posted++;
        for (int i = 0; i < 400 && tx_taken != tx_posted; i++) @(negedge xclk);
        check("tx byte consumed", tx_taken, tx_posted);
        tick(6);
        exp_rdfin++;
        exp_rdsub = (exp_rdsub + 1) % 8;
        check("TXDR data", last_tx, b);
    endtask

    task automatic check_model(input string tag);
        check({tag, " PRWA"}, xi_prwa, exp_prwa);
        check({tag, " PD"}, xi_pd, exp_pd);
        check({tag, " PWr count"}, pwr_n, exp_pwr);
        check({tag, " PWrSubA"}, wrsub, exp_wrsub);
        check({tag, " PRdSubA"}, rdsub, exp_rdsub);
        check({tag, " PRdFinished count"}, rdfin_n, exp_rdfin);
    endtask

    task automatic wait_ce(input int n0);
        for (int i = 0; i < 600 && n_ce == n0; i++) @(negedge xclk);
        check("init completes", n_ce, n0 + 1);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [2:0] prwa;
        logic [5:0] pd;
        int         npwr;
        logic [2:0] wrsub;
    } vec_t;

    vec_t vecs [7];
    logic [16:0] exp_log [7];

    initial begin
        int n0, p0, t0;
        logic [7:0] rb;
        xo = 8'h00;
        vecs[0] = '{8'h45, 3'd5, 6'h00, 0, 3'd0};
        vecs[1] = '{8'h8A, 3'd5, 6'h0A, 1, 3'd1};
        vecs[2] = '{8'h91, 3'd5, 6'h11, 1, 3'd2};
        vecs[3] = '{8'hBF, 3'd5, 6'h3F, 1, 3'd3};
        vecs[4] = '{8'h3F, 3'd5, 6'h3F, 0, 3'd3};
        vecs[5] = '{8'hC2, 3'd5, 6'h3F, 0, 3'd3};
        vecs[6] = '{8'h6E, 3'd6, 6'h3F, 0, 3'd0};
        exp_log[0] = {1'b1, 8'h41, 8'h04};
        exp_log[1] = {1'b0, 8'h45, 8'h00};
        exp_log[2] = {1'b0, 8'h47, 8'h00};
        exp_log[3] = {1'b0, 8'h47, 8'h00};
        exp_log[4] = {1'b1, 8'h41, 8'h00};
        exp_log[5] = {1'b0, 8'h45, 8'h00};
        exp_log[6] = {1'b0, 8'h45, 8'h00};

        // Reset values
        tick(3);
        check("reset cyc", wb_cyc, 0);
        check("reset stb", wb_stb, 0);
        check("reset adr", wb_adr, 0);
        check("reset PRWA", xi_prwa, 0);
        check("reset err_count", err_cnt, 0);
        check("reset err_timeout", err_to, 0);
        rst = 1'b0;

        // Init sequence then idle polling
        wait_ce(0);
        tick(30);
        for (int i = 0; i < 7; i++) check($sformatf("init txn %0d", i), log_e[i], exp_log[i]);
        check("u2 first write adr", first_adr2, 8'h4B);
        check("u2 first write dat", first_dat2, 8'h04);
        ack2_en = 1'b0;

        // Vector table: address byte, three data bytes, dropped types, new address
        for (int i = 0; i < 7; i++) begin
            p0 = pwr_n;
            send_rx(vecs[i].b);
            check($sformatf("vec %0d PRWA", i), xi_prwa, vecs[i].prwa);
            check($sformatf("vec %0d PD", i), xi_pd, vecs[i].pd);
            check($sformatf("vec %0d PWr pulses", i), pwr_n - p0, vecs[i].npwr);
            check($sformatf("vec %0d PWrSubA", i), wrsub, vecs[i].wrsub);
            check($sformatf("vec %0d PRdSubA", i), rdsub, 0);
        end

        // Nine data bytes: write subaddress wraps 7 -> 0 and ends at 1
        for (int i = 0; i < 9; i++) begin
            send_rx(8'h80 | 8'(i));
            if (i == 7) check("wrsub wrap to 0", wrsub, 0);
        end
        check("wrsub after nine", wrsub, 1);
        check_model("nine");

        // Slave transmit: TXDR write, one PRdFinished, PRdSubA steps
        send_tx(8'hA5);
        check_model("tx A5");
        check("PRdSubA after one read", rdsub, 1);

        // Random mixed traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) send_tx(rb);
            else send_rx(rb);
            check_model($sformatf("rand %0d", i));
        end

        // Last-byte NAK returns to START
        n0 = n_start;
        t0 = n_ce;
        base_sr = 8'h76;
        for (int i = 0; i < 200 && n_start == n0; i++) @(negedge xclk);
        check("lastNak restarts", n_start, n0 + 1);
        base_sr = 8'h00;
        wait_ce(t0);
        send_rx(8'h9C);
        check_model("after nak");

        // Ack withheld: one timeout after ACK_TIMEOUT clocks
        n0 = to_n;
        ack_en = 1'b0;
        for (int i = 0; i < 600 && to_n == n0; i++) @(negedge xclk);
        ack_en = 1'b1;
        t0 = n_ce;
        check("timeout pulses", to_n, n0 + 1);
        check("timeout pulse width", to_hi, 1);
        check("cyc length before abort", last_run, 255);
        check("err_count after timeout", err_cnt, 1);
        wait_ce(t0);
        tick(10);
        check("single timeout only", to_n, n0 + 1);
        send_tx(8'h3C);
        check_model("after timeout");

        // Second DUT saturates its error counter
        for (int i = 0; i < 3000 && to2_n < 300; i++) @(negedge xclk);
        check("u2 at least 300 timeouts", int'(to2_n >= 300), 1);
        check("u2 err_count saturated", ec2, 255);

        // Reset while a strobe is held
        ack_en = 1'b0;
        for (int i = 0; i < 100 && !wb_stb; i++) @(negedge xclk);
        check("stb high before reset", wb_stb, 1);
        #2 rst = 1'b1;
        #1;
        check("stb drops on reset", wb_stb, 0);
        check("cyc drops on reset", wb_cyc, 0);
        check("we drops on reset", wb_we, 0);
        check("PRWA zero on reset", xi_prwa, 0);
        check("PD zero on reset", xi_pd, 0);
        check("subs zero on reset", {rdsub, wrsub}, 0);
        check("err_count zero on reset", err_cnt, 0);
        ack_en = 1'b1;
        tick(2);
        rst = 1'b0;
        wait_ce(n_ce);
        tick(2);
        for (int i = 0; i < 5; i++) check($sformatf("replay txn %0d", i), log_e[i], exp_log[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
